// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and constants for the counter run arbiter
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin one-hot grant
// Searches upward from the slot after i_last, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt
);

  logic          w_found;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(i_last) + k) % N);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_run_arbiter.sv
// rtl/counter_run_arbiter.sv - time-shares one up/down counter among NREQ requesters
// Each accepted command steps the counter once per unheld cycle, then pulses done.
module counter_run_arbiter
  import counter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int CNT_W = 3,
  parameter int LEN_W = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_dir,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  run_hold,
  output logic [CNT_W-1:0]      cnt_value,
  output logic                  busy,
  output logic [IW-1:0]         grant_id,
  output logic                  done_valid,
  output logic [IW-1:0]         done_id
);

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic [LEN_W-1:0] r_rem;
  logic [IW-1:0]    r_grant;
  logic [IW-1:0]    r_last;

  logic [NREQ-1:0]  w_gnt;
  logic             w_accept;
  logic             w_step;
  logic [IW-1:0]    w_sel;
  logic             w_sel_dir;
  logic [LEN_W-1:0] w_sel_len;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .i_req  (req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt)
  );

  assign req_ready = (r_state == IDLE) ? w_gnt : '0;
  assign w_accept  = |(req_valid & req_ready);
  assign w_step    = (r_state == RUN) && !run_hold;

  always_comb begin
    w_sel     = '0;
    w_sel_dir = DIR_UP;
    w_sel_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        w_sel     = IW'(i);
        w_sel_dir = req_dir[i];
        w_sel_len = req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (w_sel_len != '0) ? RUN : DONE;
      RUN:     if (w_step && r_rem == LEN_W'(1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The counter value deliberately survives between runs; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_dir   <= DIR_UP;
      r_rem   <= '0;
      r_grant <= '0;
      r_last  <= IW'(NREQ - 1);
    end else begin
      if (w_accept) begin
        r_grant <= w_sel;
        r_dir   <= w_sel_dir;
        r_rem   <= w_sel_len;
        r_last  <= w_sel;
      end
      if (w_step) begin
        r_cnt <= (r_dir == DIR_DOWN) ? r_cnt - 1'b1 : r_cnt + 1'b1;
        r_rem <= r_rem - 1'b1;
      end
    end
  end

  assign cnt_value  = r_cnt;
  assign busy       = (r_state != IDLE);
  assign grant_id   = r_grant;
  assign done_valid = (r_state == DONE);
  assign done_id    = r_grant;

endmodule

// File: tb/tb_counter_run_arbiter.sv
// tb/tb_counter_run_arbiter.sv - scoreboard bench for counter_run_arbiter
module tb_counter_run_arbiter;

  localparam int NREQ  = 4;
  localparam int CNT_W = 3;
  localparam int LEN_W = 4;
  localparam int IW    = $clog2(NREQ);
  localparam int CMASK = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_dir = '0;
  logic [NREQ*LEN_W-1:0] req_len = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  run_hold = 1'b0;
  logic [CNT_W-1:0]      cnt_value;
  logic                  busy;
  logic [IW-1:0]         grant_id;
  logic                  done_valid;
  logic [IW-1:0]         done_id;

  counter_run_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_dir    (req_dir),
    .req_len    (req_len),
    .req_ready  (req_ready),
    .run_hold   (run_hold),
    .cnt_value  (cnt_value),
    .busy       (busy),
    .grant_id   (grant_id),
    .done_valid (done_valid),
    .done_id    (done_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int cnt;
    int cyc;
  } done_t;

  done_t exp_done[$];
  int    exp_grant[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: accepted commands and completion pulses against the queues.
  always @(negedge clk) begin
    done_t e;
    int    g;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        if (exp_grant.size() == 0) begin
          check("unexpected_accept", i, -1);
        end else begin
          g = exp_grant.pop_front();
          check("grant_order", i, g);
        end
      end
    end
    if (done_valid) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", int'(done_id), -1);
      end else begin
        e = exp_done.pop_front();
        check("done_id", int'(done_id), e.id);
        check("done_cnt", int'(cnt_value), e.cnt);
        check("done_busy", int'(busy), 1);
        if (e.cyc >= 0) check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_accept(input int id, output int c);
    bit ok = 1'b0;
    c = -1;
    for (int t = 0; t < 30 && !ok; t++) begin
      @(negedge clk);
      if (req_valid[id] && req_ready[id]) begin
        ok = 1'b1;
        c  = cyc;
      end
    end
    check("accept_seen", int'(ok), 1);
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      if (exp_done.size() == 0 && !busy) ok = 1'b1;
    end
    check("drain", int'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int id, input logic dir, input int len, input int end_cnt,
                         input int chk_start, input int hold_n);
    int c;
    exp_grant.push_back(id);
    req_dir[id] = dir;
    req_len[id*LEN_W +: LEN_W] = LEN_W'(len);
    req_valid[id] = 1'b1;
    wait_accept(id, c);
    exp_done.push_back('{id, end_cnt, c + 1 + len + hold_n});
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    if (chk_start >= 0) begin
      for (int k = 1; k <= len; k++) begin
        @(posedge clk);
        @(negedge clk);
        check("step_cnt", int'(cnt_value), (chk_start + (dir ? -k : k)) & CMASK);
      end
    end
    if (hold_n > 0) begin
      @(posedge clk);
      #1 run_hold = 1'b1;
      repeat (hold_n) @(posedge clk);
      #1 run_hold = 1'b0;
    end
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int naccept;
    int rr_ids[9] = '{0, 1, 2, 3, 0, 1, 3, 0, 1};
    int rr_cnt[9] = '{3, 4, 5, 6, 7, 0, 1, 2, 3};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_cnt", int'(cnt_value), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_done_valid", int'(done_valid), 0);
    check("rst_done_id", int'(done_id), 0);
    check("rst_ready", int'(req_ready), 0);
    @(posedge clk);
    #1;

    run_one(0, 1'b0, 5, 5, 0, 0);     // 1,2,3,4,5
    run_one(2, 1'b0, 4, 1, 5, 0);     // 6,7,0,1
    run_one(2, 1'b1, 2, 7, 1, 0);     // 0,7
    run_one(3, 1'b0, 3, 2, -1, 2);    // 0,1,2 with two held cycles

    for (int i = 0; i < 9; i++) begin
      exp_grant.push_back(rr_ids[i]);
      exp_done.push_back('{rr_ids[i], rr_cnt[i], -1});
    end
    for (int i = 0; i < NREQ; i++) req_len[i*LEN_W +: LEN_W] = LEN_W'(1);
    req_dir   = '0;
    req_valid = '1;
    naccept   = 0;
    for (int t = 0; t < 100 && naccept < 9; t++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        naccept++;
        @(posedge clk);
        #1;
        if (naccept == 5) req_valid[2] = 1'b0;
        if (naccept == 9) req_valid = '0;
      end
    end
    check("rr_accepts", naccept, 9);
    wait_drain();

    run_one(1, 1'b0, 0, 3, -1, 0);    // zero length: done next cycle, no change

    exp_grant.push_back(1);
    req_dir[1] = 1'b0;
    req_len[1*LEN_W +: LEN_W] = LEN_W'(6);
    req_valid[1] = 1'b1;
    wait_accept(1, c);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("pre_abort_cnt", int'(cnt_value), 5);
    @(posedge clk);
    @(negedge clk);
    check("abort_cnt", int'(cnt_value), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done_valid", int'(done_valid), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    exp_grant.push_back(0);
    for (int i = 0; i < NREQ; i++) req_len[i*LEN_W +: LEN_W] = LEN_W'(1);
    req_dir = '0;
    req_valid = 4'b1011;
    wait_accept(0, c);
    exp_done.push_back('{0, 1, c + 2});
    @(posedge clk);
    #1 req_valid = '0;
    wait_drain();

    check("grant_queue_empty", exp_grant.size(), 0);
    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
